// File: rtl/clk_en_gen.sv
// clk_en_gen: NUM_CH fractional-rate clock-enable generator for the system
// clock domain. Enables are gated until the PLL lock is synchronised and has
// been stable for LOCK_DELAY clocks; ratios are runtime-writable per channel.

// One enable channel: phase accumulator producing num/den pulses per clock.
module clk_en_ch #(
    parameter int               ACC_W   = 16,
    parameter logic [ACC_W-1:0] NUM_RST = '0,
    parameter logic [ACC_W-1:0] DEN_RST = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,    // accumulate this clock
    input  logic             flush,   // lock lost: drop phase
    input  logic             wr,      // ratio write for this channel
    input  logic [ACC_W-1:0] wr_num,
    input  logic [ACC_W-1:0] wr_den,
    output logic             ce
);
    logic [ACC_W-1:0] num, den, acc;
    logic [ACC_W:0]   sum, diff;

    // One extra bit so acc + num never wraps before the compare.
    assign sum  = {1'b0, acc} + {1'b0, num};
    assign diff = sum - {1'b0, den};

    // Ratio registers, accumulator and registered enable pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num <= NUM_RST;
            den <= DEN_RST;
            acc <= '0;
            ce  <= 1'b0;
        end else if (wr) begin
            // New ratio restarts the phase; it takes effect next clock.
            num <= wr_num;
            den <= wr_den;
            acc <= '0;
            ce  <= 1'b0;
        end else if (flush) begin
            acc <= '0;
            ce  <= 1'b0;
        end else if (step) begin
            if (num == '0 || den == '0) begin
                acc <= '0;
                ce  <= 1'b0;
            end else if (num >= den) begin
                // Rate >= 1: solid enable, phase kept at zero.
                acc <= '0;
                ce  <= 1'b1;
            end else if (sum >= {1'b0, den}) begin
                acc <= diff[ACC_W-1:0];
                ce  <= 1'b1;
            end else begin
                acc <= sum[ACC_W-1:0];
                ce  <= 1'b0;
            end
        end else begin
            // Paused or not running: hold phase, no pulses.
            ce <= 1'b0;
        end
    end
endmodule

module clk_en_gen #(
    parameter int                       NUM_CH     = 4,
    parameter int                       ACC_W      = 16,
    parameter int                       LOCK_DELAY = 1024,
    parameter logic [NUM_CH*ACC_W-1:0]  NUM_INIT   = {4{16'd1}},
    parameter logic [NUM_CH*ACC_W-1:0]  DEN_INIT   = {16'd16, 16'd24, 16'd16, 16'd32},
    localparam int                      SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              pause,
    input  logic              cfg_we,
    input  logic [SEL_W-1:0]  cfg_sel,
    input  logic [ACC_W-1:0]  cfg_num,
    input  logic [ACC_W-1:0]  cfg_den,
    output logic [NUM_CH-1:0] ce,
    output logic              ready
);
    localparam int             CNT_W    = $clog2(LOCK_DELAY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       sync;
    logic             lk, run_st, step, flush;

    assign lk     = sync[1];
    assign run_st = (state == RUN);
    assign step   = run_st & lk & ~pause;
    assign flush  = run_st & ~lk;

    // Two-flop synchroniser for the asynchronous PLL lock flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b00;
        else        sync <= {sync[0], pll_locked};
    end

    // Lock qualification: the first clock that sees lk counts as settle clock 1,
    // so RUN is entered after LOCK_DELAY consecutive clocks of lk high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    cnt   <= '0;
                    ready <= 1'b0;
                    if (lk) begin
                        if (LOCK_DELAY == 1) begin
                            state <= RUN;
                            ready <= 1'b1;
                        end else begin
                            state <= SETTLE;
                            cnt   <= CNT_ONE;
                        end
                    end
                end
                SETTLE: begin
                    if (!lk) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RUN: begin
                    if (!lk) begin
                        state <= WAIT_LOCK;
                        ready <= 1'b0;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= WAIT_LOCK;
                    ready <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Channel array; an out-of-range cfg_sel matches no instance.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_en_ch #(
            .ACC_W   (ACC_W),
            .NUM_RST (NUM_INIT[i*ACC_W +: ACC_W]),
            .DEN_RST (DEN_INIT[i*ACC_W +: ACC_W])
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .step   (step),
            .flush  (flush),
            .wr     (cfg_we && (cfg_sel == SEL_W'(i))),
            .wr_num (cfg_num),
            .wr_den (cfg_den),
            .ce     (ce[i])
        );
    end
endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen with LOCK_DELAY=8. A second 5-channel
// instance exists so that an out-of-range cfg_sel (7) is representable.
module tb_clk_en_gen;
    logic        clk = 1'b0;
    logic        rst_n, pll_locked, pause;
    logic        cfg_we, cfg_we2;
    logic [1:0]  cfg_sel;
    logic [2:0]  cfg_sel2;
    logic [15:0] cfg_num, cfg_den;
    logic [3:0]  ce;
    logic [4:0]  ce2;
    logic        ready, ready2;

    int n_chk = 0;
    int n_fail = 0;
    int n, np, last, g;

    always #5 clk = ~clk;

    clk_en_gen #(
        .NUM_CH(4), .ACC_W(16), .LOCK_DELAY(8),
        .NUM_INIT({4{16'd1}}),
        .DEN_INIT({16'd32, 16'd16, 16'd24, 16'd16})   // ch0=16 ch1=24 ch2=16 ch3=32
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .pause(pause),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_num(cfg_num), .cfg_den(cfg_den),
        .ce(ce), .ready(ready)
    );

    clk_en_gen #(
        .NUM_CH(5), .ACC_W(16), .LOCK_DELAY(8),
        .NUM_INIT({5{16'd1}}),
        .DEN_INIT({16'd8, 16'd32, 16'd16, 16'd24, 16'd16})
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .pause(pause),
        .cfg_we(cfg_we2), .cfg_sel(cfg_sel2), .cfg_num(cfg_num), .cfg_den(cfg_den),
        .ce(ce2), .ready(ready2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Default pattern k clocks after ready: ch0 /16, ch1 /24, ch2 /16, ch3 /32.
    function automatic logic [3:0] dflt(input int k);
        return {k % 32 == 0, k % 16 == 0, k % 24 == 0, k % 16 == 0};
    endfunction

    // ch2 at 3/8 from a cleared phase: pulses when k mod 8 is 3, 6 or 0.
    function automatic logic p38(input int k);
        return (k % 8 == 3) || (k % 8 == 6) || (k % 8 == 0);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; pll_locked = 1'b0; pause = 1'b0;
        cfg_we = 1'b0; cfg_sel = '0; cfg_we2 = 1'b0; cfg_sel2 = '0;
        cfg_num = '0; cfg_den = '0;
        repeat (3) tick();
        chk("reset_ce", 32'(ce), 32'd0);
        chk("reset_ready", 32'(ready), 32'd0);
        rst_n = 1'b1;
        repeat (4) tick();
        chk("nolock_ready", 32'(ready), 32'd0);

        // Lock: 2 sync clocks + 8 settle clocks.
        pll_locked = 1'b1;
        n = 0;
        while (!ready && n < 40) begin
            tick(); n++;
            if (!ready) chk("settle_ce", 32'(ce), 32'd0);
        end
        chk("lock_latency", n, 10);

        // Default ratios; dut2 sees ignored writes to sel 7 and 5.
        for (int k = 1; k <= 96; k++) begin
            tick();
            chk("dflt_ce", 32'(ce), 32'(dflt(k)));
            chk("dut2_ce", 32'(ce2), 32'({k % 8 == 0, dflt(k)}));
            if (k == 40) begin cfg_we2 = 1'b1; cfg_sel2 = 3'd7; end
            else if (k == 41) cfg_sel2 = 3'd5;
            else if (k == 42) cfg_we2 = 1'b0;
        end

        // ch2 -> 3/8: 30 pulses in 80 clocks, gaps 2 or 3; others undisturbed.
        cfg_we = 1'b1; cfg_sel = 2'd2; cfg_num = 16'd3; cfg_den = 16'd8;
        np = 0; last = -1;
        for (int k = 97; k <= 177; k++) begin
            tick();
            if (k == 97) begin
                cfg_we = 1'b0;
                chk("wr_edge_ce2", 32'(ce[2]), 32'd0);
            end else if (ce[2]) begin
                np++;
                if (last >= 0) begin
                    g = k - last;
                    chk("gap_2_or_3", 32'(g == 2 || g == 3), 32'd1);
                end
                last = k;
            end
            chk("others_phase", 32'(ce & 4'b1011), 32'(dflt(k) & 4'b1011));
        end
        chk("pulses_80", np, 30);

        // One-clock lock drop in RUN.
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        n = 1;
        while (ready && n < 10) begin tick(); n++; end
        chk("drop_latency", 32'(n >= 2 && n <= 3), 32'd1);
        chk("drop_ce", 32'(ce), 32'd0);
        n = 0;
        while (!ready && n < 40) begin
            tick(); n++;
            chk("resettle_ce", 32'(ce), 32'd0);
        end
        chk("resettle_len", n, 8);

        // Restart from zero phase; ch2 keeps its 3/8 ratio.
        for (int k = 1; k <= 53; k++) begin
            tick();
            chk("restart_ce", 32'(ce), 32'({k % 32 == 0, p38(k), k % 24 == 0, k % 16 == 0}));
        end

        // ch0 phase is 5 here; pause 50 clocks.
        pause = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            chk("pause_ce", 32'(ce), 32'd0);
        end
        pause = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!ce[0] && n < 40);
        chk("resume_latency", n, 11);

        // Degenerate ratios on ch2.
        cfg_we = 1'b1; cfg_sel = 2'd2; cfg_num = 16'd0; cfg_den = 16'd8;
        tick(); cfg_we = 1'b0;
        for (int k = 0; k < 20; k++) begin tick(); chk("num0_ce2", 32'(ce[2]), 32'd0); end
        cfg_we = 1'b1; cfg_num = 16'd3; cfg_den = 16'd0;
        tick(); cfg_we = 1'b0;
        for (int k = 0; k < 20; k++) begin tick(); chk("den0_ce2", 32'(ce[2]), 32'd0); end
        cfg_we = 1'b1; cfg_num = 16'd5; cfg_den = 16'd5;
        tick(); cfg_we = 1'b0;
        chk("eq_wr_edge", 32'(ce[2]), 32'd0);
        for (int k = 0; k < 12; k++) begin tick(); chk("eq_const1", 32'(ce[2]), 32'd1); end
        cfg_we = 1'b1; cfg_num = 16'd7; cfg_den = 16'd5;
        tick(); cfg_we = 1'b0;
        for (int k = 0; k < 12; k++) begin tick(); chk("gt_const1", 32'(ce[2]), 32'd1); end

        // Asynchronous reset mid-operation restores default ratios.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_ce", 32'(ce), 32'd0);
        chk("async_ready", 32'(ready), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        n = 0;
        while (!ready && n < 40) begin tick(); n++; end
        chk("relock_latency", n, 10);
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk("post_reset_ce", 32'(ce), 32'(dflt(k)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
